menu_text_renderer: RTL and testbench

- Reader end of the menu text-buffer write interface driven by the configuration state machine.
- Owns the 80-column x 12-row character buffer and accepts single-cycle writes into it.
- Scans the buffer against the video raster (hcount/vcount), fetches glyph rows from an external 8x8 font ROM, and emits a per-pixel menu colour with the current cursor row highlighted and blinking.
- Sits between the config block and the video output mux; its output is shown only while the menu is active.

---
 rtl/menu_text_renderer_if.sv | 10 +
 rtl/menu_text_renderer.sv | 127 ++++++++++++
 tb/tb_menu_text_renderer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/menu_text_renderer_if.sv
// Menu text-buffer write port between the configuration FSM (master)
// and the text renderer (slave). Single-cycle writes, no backpressure.
interface menu_text_renderer_if;
  logic       write_valid_in;
  logic [9:0] write_addr_in;
  logic [7:0] write_data_in;

  modport master (output write_valid_in, output write_addr_in, output write_data_in);
  modport slave  (input  write_valid_in, input  write_addr_in, input  write_data_in);
endinterface

// File: rtl/menu_text_renderer.sv
// Menu overlay: owns the 80x12 character buffer, scans it against the raster,
// fetches 8x8 glyph rows from an external font ROM and emits 2x-scaled pixels.
module menu_text_renderer #(
  parameter int TEXT_COLS       = 80,
  parameter int TEXT_ROWS       = 12,
  parameter int V_OFFSET        = 64,
  parameter int CURSOR_ROW_BASE = 1,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic        clk_in,
  input  logic        rst_in,
  menu_text_renderer_if.slave wr,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_in,
  input  logic        new_frame_in,
  input  logic [3:0]  ptr_index_in,
  input  logic        active_processor_in,
  input  logic [23:0] fg_color_in,
  input  logic [23:0] bg_color_in,
  output logic [9:0]  font_addr_out,
  input  logic [7:0]  font_data_in,
  output logic [23:0] pixel_out,
  output logic        text_on_out
);
  localparam int NCELL  = TEXT_COLS * TEXT_ROWS;
  localparam int STAGES = 4;
  localparam int BW     = $clog2(BLINK_FRAMES);

  typedef struct packed {
    logic       on;
    logic       cur;
    logic       hide;
    logic       inv;
    logic [2:0] gcol;
    logic [2:0] grow;
  } side_t;

  logic [7:0]        mem [0:NCELL-1];
  logic [7:0]        char_q;
  logic [9:0]        addr_q;
  side_t             sb [STAGES:0];
  logic [STAGES:0]   vld_pipe;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic [3:0]        ptr_q;

  logic [9:0] ty;
  logic [5:0] row;
  logic [6:0] col;
  logic [5:0] cur_row;
  logic       in_reg;
  logic [9:0] addr_n;
  logic       px_bit;
  logic       px_inv;

  // Row keeps ty[9] so raster lines past 512 below V_OFFSET can't alias row 0.
  always_comb begin
    ty      = vcount_in - 10'(V_OFFSET);
    row     = ty[9:4];
    col     = hcount_in[10:4];
    cur_row = 6'({1'b0, ptr_index_in} + 5'(CURSOR_ROW_BASE));
    in_reg  = active_in && (vcount_in >= 10'(V_OFFSET)) &&
              (row < 6'(TEXT_ROWS)) && (col < 7'(TEXT_COLS));
    addr_n  = in_reg ? (10'(row) * 10'(TEXT_COLS) + 10'(col)) : '0;
  end

  always_comb begin
    px_bit = font_data_in[3'd7 - sb[STAGES].gcol];
    px_inv = sb[STAGES].inv ^ (sb[STAGES].cur & blink_phase);
  end

  // Read-first buffer: the registered read sees the pre-write contents.
  always_ff @(posedge clk_in) begin
    if (!rst_in && wr.write_valid_in && (wr.write_addr_in < 10'(NCELL)))
      mem[wr.write_addr_in] <= wr.write_data_in;
    char_q <= mem[addr_q];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_pipe      <= '0;
      for (int i = 0; i <= STAGES; i++) sb[i] <= '0;
      addr_q        <= '0;
      font_addr_out <= '0;
      pixel_out     <= '0;
      text_on_out   <= 1'b0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b1;
      ptr_q         <= ptr_index_in;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      addr_q   <= addr_n;
      sb[0]    <= '{on: in_reg, cur: in_reg && (row == cur_row), hide: active_processor_in,
                    inv: 1'b0, gcol: hcount_in[3:1], grow: ty[3:1]};
      sb[1]    <= sb[0];
      sb[2]    <= {sb[1].on, sb[1].cur, sb[1].hide, char_q[7], sb[1].gcol, sb[1].grow};
      font_addr_out <= {char_q[6:0], sb[1].grow};
      for (int i = 3; i <= STAGES; i++) sb[i] <= sb[i-1];

      if (!vld_pipe[STAGES] || sb[STAGES].hide) begin
        pixel_out   <= '0;
        text_on_out <= 1'b0;
      end else if (!sb[STAGES].on) begin
        pixel_out   <= bg_color_in;
        text_on_out <= 1'b0;
      end else begin
        pixel_out   <= (px_bit ^ px_inv) ? fg_color_in : bg_color_in;
        text_on_out <= 1'b1;
      end

      // A cursor move restarts the blink visible so the new row shows at once.
      ptr_q <= ptr_index_in;
      if (ptr_index_in != ptr_q) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (new_frame_in) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_menu_text_renderer.sv
// Bench for menu_text_renderer: vector table through a 5-deep scoreboard,
// plus hand sequences for blink, collision, hide and mid-row reset.
module tb_menu_text_renderer;
  localparam logic [23:0] FG = 24'h123456;
  localparam logic [23:0] BG = 24'hABCDEF;
  localparam int LAT = 5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        active_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic [3:0]  ptr_index_in = 4'd5;
  logic        active_processor_in = 1'b0;
  logic [23:0] fg_color_in = FG;
  logic [23:0] bg_color_in = BG;
  logic [9:0]  font_addr_out;
  logic [7:0]  font_data_in;
  logic [23:0] pixel_out;
  logic        text_on_out;

  menu_text_renderer_if wif();

  menu_text_renderer dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr(wif),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .active_in(active_in),
    .new_frame_in(new_frame_in), .ptr_index_in(ptr_index_in),
    .active_processor_in(active_processor_in),
    .fg_color_in(fg_color_in), .bg_color_in(bg_color_in),
    .font_addr_out(font_addr_out), .font_data_in(font_data_in),
    .pixel_out(pixel_out), .text_on_out(text_on_out)
  );

  always #5 clk_in = ~clk_in;

  // Font ROM model, 2-cycle read latency.
  function automatic logic [7:0] font(input logic [6:0] g);
    case (g)
      7'h41:   return 8'h80;
      7'h42:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction
  logic [7:0] rom_q1 = '0, rom_q2 = '0;
  always @(posedge clk_in) begin
    rom_q1 <= font(font_addr_out[9:3]);
    rom_q2 <= rom_q1;
  end
  assign font_data_in = rom_q2;

  typedef struct {
    bit          chk;
    int          id;
    logic [23:0] pix;
    logic        on;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int          x, y;
    logic        act;
    logic [3:0]  ptr;
    logic        hide;
    logic [23:0] pix;
    logic        on;
  } vec_t;
  vec_t vt[$];

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, id, act, exp);
    end
  endtask

  // One clock: push the expectation for the inputs just sampled, compare the one LAT edges old.
  task automatic step(input bit c, input logic [23:0] p, input logic o, input int id);
    exp_t e;
    @(posedge clk_in); #1;
    e = '{chk: c, id: id, pix: p, on: o};
    q.push_back(e);
    if (q.size() > LAT) begin
      e = q.pop_front();
      if (e.chk) begin
        check("pixel", e.id, 32'(pixel_out), 32'(e.pix));
        check("text_on", e.id, 32'(text_on_out), 32'(e.on));
      end
    end
    new_frame_in = 1'b0;
    wif.write_valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT) step(1'b0, '0, 1'b0, 0);
  endtask

  task automatic px(input int x, input int y);
    hcount_in = 11'(x);
    vcount_in = 10'(y);
    active_in = 1'b1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wif.write_valid_in = 1'b1;
    wif.write_addr_in  = 10'(a);
    wif.write_data_in  = d;
  endtask

  function automatic vec_t mk(input int x, input int y, input logic act, input logic [3:0] ptr,
                              input logic hide, input logic [23:0] pix, input logic on);
    return '{x: x, y: y, act: act, ptr: ptr, hide: hide, pix: pix, on: on};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wif.write_valid_in = 1'b0;
    wif.write_addr_in  = '0;
    wif.write_data_in  = '0;

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_pixel", 0, 32'(pixel_out), 32'h0);
    check("rst_text_on", 0, 32'(text_on_out), 32'h0);
    check("rst_font_addr", 0, 32'(font_addr_out), 32'h0);
    rst_in = 1'b0;

    for (int a = 0; a < 960; a++) begin wr(a, 8'h00); step(1'b0, '0, 1'b0, 0); end
    wr(85, 8'h41);   step(1'b0, '0, 1'b0, 0);
    wr(86, 8'hC1);   step(1'b0, '0, 1'b0, 0);
    wr(165, 8'h41);  step(1'b0, '0, 1'b0, 0);
    wr(959, 8'h42);  step(1'b0, '0, 1'b0, 0);
    wr(1000, 8'h41); step(1'b0, '0, 1'b0, 0);

    for (int x = 80; x < 96; x++) vt.push_back(mk(x, 80, 1, 5, 0, (x < 82) ? FG : BG, 1));
    vt.push_back(mk(1264, 240, 1, 5, 0, BG, 1));
    vt.push_back(mk(1276, 240, 1, 5, 0, BG, 1));
    vt.push_back(mk(1278, 240, 1, 5, 0, FG, 1));
    vt.push_back(mk(1279, 240, 1, 5, 0, FG, 1));
    vt.push_back(mk(80, 256, 1, 5, 0, BG, 0));
    vt.push_back(mk(640, 64, 1, 5, 0, BG, 1));
    vt.push_back(mk(80, 63, 1, 5, 0, BG, 0));
    vt.push_back(mk(1280, 80, 1, 5, 0, BG, 0));
    vt.push_back(mk(80, 80, 0, 5, 0, BG, 0));
    vt.push_back(mk(80, 80, 1, 5, 1, 24'h0, 0));
    vt.push_back(mk(80, 80, 1, 0, 0, BG, 1));
    vt.push_back(mk(82, 80, 1, 0, 0, FG, 1));
    vt.push_back(mk(96, 80, 1, 0, 0, FG, 1));
    vt.push_back(mk(98, 80, 1, 0, 0, BG, 1));
    vt.push_back(mk(80, 64, 1, 0, 0, BG, 1));
    vt.push_back(mk(80, 96, 1, 0, 0, FG, 1));
    vt.push_back(mk(1264, 240, 1, 11, 0, BG, 1));
    vt.push_back(mk(1278, 240, 1, 11, 0, FG, 1));
    vt.push_back(mk(1264, 240, 1, 10, 0, FG, 1));
    vt.push_back(mk(1278, 240, 1, 10, 0, BG, 1));

    for (int i = 0; i < vt.size(); i++) begin
      hcount_in = 11'(vt[i].x);
      vcount_in = 10'(vt[i].y);
      active_in = vt[i].act;
      ptr_index_in = vt[i].ptr;
      active_processor_in = vt[i].hide;
      step(1'b1, vt[i].pix, vt[i].on, i);
    end
    active_processor_in = 1'b0;
    drain();

    // Font address two edges after the pixel is sampled: {0x41, row 0}.
    ptr_index_in = 4'd5;
    px(80, 80);
    repeat (3) step(1'b0, '0, 1'b0, 0);
    check("font_addr", 100, 32'(font_addr_out), 32'h208);
    drain();

    // Blink: 29 pulses keep the highlight, the 30th drops it.
    ptr_index_in = 4'd0;
    px(82, 80);
    step(1'b0, '0, 1'b0, 0);
    for (int k = 0; k < 29; k++) begin
      new_frame_in = 1'b1;
      step(1'b0, '0, 1'b0, 0);
      step(1'b0, '0, 1'b0, 0);
    end
    step(1'b1, FG, 1'b1, 101);
    drain();
    new_frame_in = 1'b1;
    step(1'b0, '0, 1'b0, 0);
    step(1'b1, BG, 1'b1, 102);
    drain();
    ptr_index_in = 4'd1;
    px(82, 96); step(1'b1, FG, 1'b1, 103);
    px(80, 96); step(1'b1, BG, 1'b1, 104);
    px(82, 80); step(1'b1, BG, 1'b1, 105);
    drain();

    // Collision: write lands on the same edge as the read of the earlier pixel.
    ptr_index_in = 4'd5;
    step(1'b0, '0, 1'b0, 0);
    px(80, 80); step(1'b1, FG, 1'b1, 106);
    wr(85, 8'h00); step(1'b1, BG, 1'b1, 107);
    drain();

    // Hide.
    px(80, 96);
    active_processor_in = 1'b1; step(1'b1, 24'h0, 1'b0, 108);
    active_processor_in = 1'b0; step(1'b1, FG, 1'b1, 109);
    drain();

    // Mid-row reset with a dropped write to a live cell.
    px(80, 96);
    rst_in = 1'b1;
    wr(165, 8'h00);
    @(posedge clk_in); #1;
    wif.write_valid_in = 1'b0;
    check("in_rst_pixel", 110, 32'(pixel_out), 32'h0);
    check("in_rst_text_on", 110, 32'(text_on_out), 32'h0);
    @(posedge clk_in); #1;
    check("in_rst_pixel", 111, 32'(pixel_out), 32'h0);
    q.delete();
    rst_in = 1'b0;
    step(1'b1, FG, 1'b1, 112);
    check("post_rst_text_on", 113, 32'(text_on_out), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0, 0);
      check("post_rst_pixel", 114 + k, 32'(pixel_out), 32'h0);
      check("post_rst_text_on", 114 + k, 32'(text_on_out), 32'h0);
    end
    step(1'b0, '0, 1'b0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
